// File: rtl/register_file.sv
// 16x16 register file: one synchronous write port, two combinational read ports, r0 reads zero.
// Optional write-to-read forwarding is enabled by defining REG_BYPASS_EN.
module register_file (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] writeData,
  input  logic [3:0]  writeReg,
  input  logic [3:0]  read1,
  output logic [15:0] regOutA,
  input  logic [3:0]  read2,
  output logic [15:0] regOutB
);

  localparam int unsigned DataWidth = 16;
  localparam int unsigned AddrWidth = 4;
  localparam int unsigned NumRegs   = 16;

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  logic [NumRegs-1:0][DataWidth-1:0] regs;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs <= '0;
    end else begin
      for (int unsigned i = 1; i < NumRegs; i++) begin
        if (writeReg == AddrWidth'(i)) begin
          regs[i] <= writeData;
        end
      end
    end
  end

  logic [DataWidth-1:0] storedA;
  logic [DataWidth-1:0] storedB;

  always_comb begin
    storedA = '0;
    storedB = '0;
    if (read1 != '0) storedA = regs[read1];
    if (read2 != '0) storedB = regs[read2];
  end

`ifdef REG_BYPASS_EN
  // Forward the in-flight write to a port that addresses the same nonzero register.
  logic fwdA;
  logic fwdB;

  always_comb begin
    fwdA    = RST_N && (writeReg != '0) && (read1 == writeReg);
    fwdB    = RST_N && (writeReg != '0) && (read2 == writeReg);
    regOutA = fwdA ? writeData : storedA;
    regOutB = fwdB ? writeData : storedB;
  end
`else
  always_comb begin
    regOutA = storedA;
    regOutB = storedB;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default build or REG_BYPASS_EN).
module tb_register_file;

  logic        CLK;
  logic        RST_N;
  logic [15:0] writeData;
  logic [3:0]  writeReg;
  logic [3:0]  read1;
  logic [3:0]  read2;
  logic [15:0] regOutA;
  logic [15:0] regOutB;

  int nCompared;
  int nMismatched;

  register_file dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .writeData(writeData),
    .writeReg (writeReg),
    .read1    (read1),
    .regOutA  (regOutA),
    .read2    (read2),
    .regOutB  (regOutB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("FAIL %s: got 0x%04h, want 0x%04h", tag, observed, expected);
    end
  endtask

  // Present a write at the falling edge; it is captured on the following rising edge.
  task automatic doWrite(input logic [3:0] idx, input logic [15:0] data);
    @(negedge CLK);
    writeReg  = idx;
    writeData = data;
    @(posedge CLK);
    #1;
    writeReg = 4'd0;
  endtask

  logic [15:0] expSame;

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    RST_N     = 1'b1;
    writeData = 16'h0000;
    writeReg  = 4'd0;
    read1     = 4'd7;
    read2     = 4'd12;

    // Reset asserted between edges
    #2 RST_N = 1'b0;
    #1;
    checkVal("rst_a0", regOutA, 16'h0000);
    checkVal("rst_b0", regOutB, 16'h0000);
    writeReg  = 4'd7;
    writeData = 16'hDEAD;
    @(posedge CLK);
    #1;
    read1 = 4'd13;
    read2 = 4'd7;
    #1;
    checkVal("rst_wr_ignored_a", regOutA, 16'h0000);
    checkVal("rst_wr_ignored_b", regOutB, 16'h0000);
    writeReg = 4'd0;

    @(negedge CLK);
    RST_N = 1'b1;
    read1 = 4'd3;
    read2 = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      checkVal("idle_a", regOutA, 16'h0000);
      checkVal("idle_b", regOutB, 16'h0000);
    end

    // Basic write/read on consecutive edges
    doWrite(4'd3, 16'h1234);
    doWrite(4'd15, 16'hBEEF);
    read1 = 4'd3;
    read2 = 4'd15;
    #1;
    checkVal("basic_a", regOutA, 16'h1234);
    checkVal("basic_b", regOutB, 16'hBEEF);

    // r0 hardwired
    doWrite(4'd0, 16'hFFFF);
    read1 = 4'd0;
    read2 = 4'd0;
    #1;
    checkVal("r0_a", regOutA, 16'h0000);
    checkVal("r0_b", regOutB, 16'h0000);

    // Same-cycle read of write target
    doWrite(4'd5, 16'h0001);
    @(negedge CLK);
    writeReg  = 4'd5;
    writeData = 16'h00AA;
    read1     = 4'd5;
    read2     = 4'd0;
    #1;
`ifdef REG_BYPASS_EN
    expSame = 16'h00AA;
`else
    expSame = 16'h0001;
`endif
    checkVal("same_pre_a", regOutA, expSame);
    checkVal("same_pre_r0_b", regOutB, 16'h0000);
    @(posedge CLK);
    #1;
    writeReg = 4'd0;
    #1;
    checkVal("same_post_a", regOutA, 16'h00AA);

    // Full sweep
    for (int i = 1; i < 16; i++) begin
      doWrite(4'(i), 16'h1000 + 16'(i));
    end
    for (int i = 1; i < 16; i++) begin
      read1 = 4'(i);
      read2 = 4'(16 - i);
      #1;
      checkVal("sweep_a", regOutA, 16'h1000 + 16'(i));
      checkVal("sweep_b", regOutB, 16'h1000 + 16'(16 - i));
    end

    // Async reset pulse between edges, with a pending write that must not forward
    @(negedge CLK);
    read1 = 4'd3;
    read2 = 4'd13;
    #2;
    RST_N     = 1'b0;
    writeReg  = 4'd13;
    writeData = 16'h5555;
    #1;
    checkVal("midrst_a", regOutA, 16'h0000);
    checkVal("midrst_b", regOutB, 16'h0000);
    @(negedge CLK);
    writeReg = 4'd0;
    RST_N    = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 16; i++) begin
      read1 = 4'(i);
      read2 = 4'(15 - i);
      #1;
      checkVal("postrst_a", regOutA, 16'h0000);
      checkVal("postrst_b", regOutB, 16'h0000);
    end

    // Register still writable after the reset pulse
    doWrite(4'd9, 16'hA5C3);
    read1 = 4'd9;
    read2 = 4'd9;
    #1;
    checkVal("rewrite_a", regOutA, 16'hA5C3);
    checkVal("rewrite_b", regOutB, 16'hA5C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

16-entry by 16-bit general-purpose register file for the 16-bit datapath. It provides one synchronous write port and two independent asynchronous read ports, used by the decode stage to fetch operands A and B. It is written by the writeback path. Register 0 is hardwired to zero, so a write to index 0 is the no-write encoding.

## Interface
Parameters: none (widths fixed).
- CLK  input  1  system clock; all writes occur on the rising edge
- RST_N  input  1  reset, asynchronous and active-low; clears every register
- writeData  input  16  data written into register writeReg
- writeReg  input  4  destination register index; 0 means no write
- read1  input  4  read port A register index
- regOutA  output  16  contents of register read1
- read2  input  4  read port B register index
- regOutB  output  16  contents of register read2

## Operation
- Storage is registers r1..r15, 16 bits each. r0 is not stored and always reads 0x0000.
- Write: on each rising CLK edge with RST_N high, if writeReg != 0, then r[writeReg] <= writeData. If writeReg == 0, nothing changes. There is no separate write enable; writeback drives writeReg = 0 when idle.
- Read: regOutA = r[read1] and regOutB = r[read2], both purely combinational. Both ports may address the same register and return the same value.
- Reset: RST_N low immediately, without waiting for CLK, forces r1..r15 to 0x0000. Writes are ignored while RST_N is low.
- Reset deassertion is clock-independent. The first write can occur on the first rising edge after RST_N goes high.
- No X propagation from unwritten registers, because every register has a defined reset value.

## Timing
- Write latency is 1 cycle. The new value is visible on a read port after the rising edge that captures it, after combinational delay.
- Read latency is 0 cycles, combinational from read1/read2 to the outputs.
- Read of a register being written in the same cycle returns the old value until the edge, unless REG_BYPASS_EN is defined (see Configuration).
- Reset mid-operation: an assertion coinciding with a write edge means reset wins and the register reads 0x0000.
- Reset values: regOutA = regOutB = 0x0000 for any read index while RST_N is low.

## Configuration
- REG_BYPASS_EN defined: write-to-read forwarding is enabled.
  - If read1 == writeReg and writeReg != 0, regOutA = writeData combinationally, before the edge.
  - regOutB behaves the same way with read2.
  - Reading r0 still returns 0x0000.
  - Forwarding is suppressed while RST_N is low, so outputs stay 0x0000.
- REG_BYPASS_EN undefined: no forwarding; reads return stored contents only.

## Test plan
- Reset: assert RST_N low with random read indices -> regOutA = regOutB = 0x0000. Then release, with no writes (writeReg = 0) for 5 cycles -> outputs stay 0x0000.
- Basic write/read: write 0x1234 to r3 and 0xBEEF to r15 on consecutive edges. Then set read1 = 3 and read2 = 15 -> regOutA = 0x1234, regOutB = 0xBEEF.
- r0 hardwired: writeReg = 0 with writeData = 0xFFFF, then read1 = read2 = 0 -> both outputs 0x0000.
- Same-cycle read of write target: r5 holds 0x0001, then writeReg = 5 with writeData = 0x00AA and read1 = 5 before the edge.
  - Without REG_BYPASS_EN -> regOutA = 0x0001 before the edge and 0x00AA after it.
  - With REG_BYPASS_EN -> regOutA = 0x00AA before the edge.
- Full sweep: write value 0x1000 + i to ri for i = 1..15, then read all pairs (i, 16 - i) -> each output matches its written value.
- Async reset mid-run: after the sweep, pulse RST_N low between clock edges -> outputs drop to 0x0000 immediately, and all registers read 0x0000 after release.
